// File: rtl/scr1_btb_ctrl.sv
// BTB lookup/update controller in front of one scr1_dp_ram instance (read-first, 1-cycle read).
// Latency: lookup result one cycle after lookup_req; updates take effect at the next clock edge.
// Backpressure: none; accepts one lookup and one update every cycle, flush kills the in-flight lookup.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   lookup_req/lookup_pc        IFU lookup request (S0)
//   lookup_vd/hit/target        lookup result (S1)
//   upd_req/pc/taken/target     EXU branch resolution: taken installs, not-taken invalidates
//   flush                       invalidate all entries
//   ram_*                       drive of the attached scr1_dp_ram (A = write, B = read)
//
// Optional feature: define SCR1_BTB_BYPASS_EN to forward a same-cycle, same-index update
// into the colliding lookup instead of reporting a conservative miss.

module scr1_btb_ctrl #(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 32,
  localparam int IDX_W    = $clog2(BTB_DEPTH),
  localparam int TAG_W    = XLEN - 1 - IDX_W,
  localparam int ENT_W    = TAG_W + XLEN - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  // IFU lookup
  input  logic             lookup_req,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             lookup_vd,
  output logic             lookup_hit,
  output logic [XLEN-1:0]  lookup_target,
  // EXU update
  input  logic             upd_req,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target,
  input  logic             flush,
  // RAM
  output logic [IDX_W-1:0] ram_addra,
  output logic [ENT_W-1:0] ram_dina,
  output logic             ram_wena,
  output logic [IDX_W-1:0] ram_addrb,
  output logic             ram_renb,
  input  logic [ENT_W-1:0] ram_doutb
);

  // PC field split: bit 0 is always zero (halfword aligned), then index, then tag.
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;

  assign lk_idx = lookup_pc[IDX_W:1];
  assign lk_tag = lookup_pc[XLEN-1:IDX_W+1];
  assign up_idx = upd_pc[IDX_W:1];
  assign up_tag = upd_pc[XLEN-1:IDX_W+1];

  // Bit 0 of PCs and targets carries no information and is not stored.
  logic unused_bit0;
  assign unused_bit0 = lookup_pc[0] ^ upd_pc[0] ^ upd_target[0];

  // RAM drive
  assign ram_renb  = lookup_req;
  assign ram_addrb = lk_idx;
  assign ram_wena  = upd_req & upd_taken & ~flush;
  assign ram_addra = up_idx;
  assign ram_dina  = {up_tag, upd_target[XLEN-1:1]};

  // Per-entry valid bits
  logic [BTB_DEPTH-1:0] valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (upd_req) begin
      valid[up_idx] <= upd_taken;
    end
  end

  // S0 -> S1 pipeline registers
  logic             s1_vd;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_valid;
  logic             s1_coll;
  logic             flush_d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vd    <= 1'b0;
      s1_tag   <= '0;
      s1_valid <= 1'b0;
      s1_coll  <= 1'b0;
      flush_d1 <= 1'b0;
    end else begin
      s1_vd    <= lookup_req;
      s1_tag   <= lk_tag;
      // Valid bit as seen before this cycle's update lands.
      s1_valid <= valid[lk_idx];
      // The RAM is read-first, so a same-index update is invisible to this read.
      s1_coll  <= upd_req & (up_idx == lk_idx);
      flush_d1 <= flush;
    end
  end

  // S1 result
  logic [TAG_W-1:0] ram_tag;
  logic [XLEN-2:0]  ram_tgt;
  logic             ram_match;

  assign ram_tag   = ram_doutb[ENT_W-1:XLEN-1];
  assign ram_tgt   = ram_doutb[XLEN-2:0];
  assign ram_match = s1_valid & (ram_tag == s1_tag);

  assign lookup_vd = s1_vd & ~flush_d1;

`ifdef SCR1_BTB_BYPASS_EN
  // Bypass register: the colliding update, forwarded to the S1 lookup.
  logic             byp_taken;
  logic [TAG_W-1:0] byp_tag;
  logic [XLEN-2:0]  byp_tgt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_taken <= 1'b0;
      byp_tag   <= '0;
      byp_tgt   <= '0;
    end else if (upd_req & (up_idx == lk_idx)) begin
      byp_taken <= upd_taken;
      byp_tag   <= up_tag;
      byp_tgt   <= upd_target[XLEN-1:1];
    end
  end

  logic byp_match;
  assign byp_match = byp_taken & (byp_tag == s1_tag);

  always_comb begin
    lookup_hit    = 1'b0;
    lookup_target = '0;
    if (s1_coll) begin
      lookup_hit = lookup_vd & byp_match;
      if (lookup_hit) lookup_target = {byp_tgt, 1'b0};
    end else begin
      lookup_hit = lookup_vd & ram_match;
      if (lookup_hit) lookup_target = {ram_tgt, 1'b0};
    end
  end
`else
  // Collision reports a conservative miss.
  always_comb begin
    lookup_hit    = lookup_vd & ram_match & ~s1_coll;
    lookup_target = '0;
    if (lookup_hit) lookup_target = {ram_tgt, 1'b0};
  end
`endif

endmodule

// File: tb/tb_scr1_btb_ctrl.sv
// Directed self-checking bench for scr1_btb_ctrl with a behavioural read-first dual-port RAM.
// Latency: results checked one cycle after each lookup is driven.
// Backpressure: none exercised; the DUT has no stall inputs.

module tb_scr1_btb_ctrl;

  localparam int XLEN  = 32;
  localparam int DEPTH = 32;
  localparam int IDX_W = 5;
  localparam int TAG_W = XLEN - 1 - IDX_W;
  localparam int ENT_W = TAG_W + XLEN - 1;

  logic             clk;
  logic             rst_n;
  logic             lookup_req;
  logic [XLEN-1:0]  lookup_pc;
  logic             lookup_vd;
  logic             lookup_hit;
  logic [XLEN-1:0]  lookup_target;
  logic             upd_req;
  logic [XLEN-1:0]  upd_pc;
  logic             upd_taken;
  logic [XLEN-1:0]  upd_target;
  logic             flush;
  logic [IDX_W-1:0] ram_addra;
  logic [ENT_W-1:0] ram_dina;
  logic             ram_wena;
  logic [IDX_W-1:0] ram_addrb;
  logic             ram_renb;
  logic [ENT_W-1:0] ram_doutb;

  int n_checks = 0;
  int n_errors = 0;

  scr1_btb_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lookup_req    (lookup_req),
    .lookup_pc     (lookup_pc),
    .lookup_vd     (lookup_vd),
    .lookup_hit    (lookup_hit),
    .lookup_target (lookup_target),
    .upd_req       (upd_req),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .flush         (flush),
    .ram_addra     (ram_addra),
    .ram_dina      (ram_dina),
    .ram_wena      (ram_wena),
    .ram_addrb     (ram_addrb),
    .ram_renb      (ram_renb),
    .ram_doutb     (ram_doutb)
  );

  // Read-first dual-port RAM with registered output.
  logic [ENT_W-1:0] mem [DEPTH];

  always @(posedge clk) begin
    if (ram_renb) ram_doutb <= mem[ram_addrb];
    if (ram_wena) mem[ram_addra] <= ram_dina;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lookup_req = 1'b0;
    upd_req    = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic lk(input logic [31:0] pc);
    lookup_req = 1'b1;
    lookup_pc  = pc;
  endtask

  task automatic up(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    upd_req    = 1'b1;
    upd_pc     = pc;
    upd_taken  = taken;
    upd_target = tgt;
  endtask

  task automatic res(input string tag, input logic vd, input logic hit, input logic [31:0] tgt);
    check({tag, ".vd"},  {31'd0, lookup_vd},  {31'd0, vd});
    check({tag, ".hit"}, {31'd0, lookup_hit}, {31'd0, hit});
    check({tag, ".tgt"}, lookup_target, tgt);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    ram_doutb  = '0;
    rst_n      = 1'b0;
    lookup_req = 1'b0;
    lookup_pc  = '0;
    upd_req    = 1'b0;
    upd_pc     = '0;
    upd_taken  = 1'b0;
    upd_target = '0;
    flush      = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    res("reset", 1'b0, 1'b0, 32'h0);
    check("reset.wena", {31'd0, ram_wena}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold lookup: miss
    cyc();
    lk(32'h100);
    cyc();
    idle();
    res("cold", 1'b1, 1'b0, 32'h0);

    // Install 0x100 -> 0x2000, lookup hit, aliasing tag miss
    up(32'h100, 1'b1, 32'h2000);
    #1;
    check("inst.wena", {31'd0, ram_wena}, 32'd1);
    check("inst.addra", {27'd0, ram_addra}, 32'd0);
    cyc();
    idle();
    cyc();
    lk(32'h100);
    cyc();
    lk(32'h1100);
    res("hit100", 1'b1, 1'b1, 32'h2000);
    cyc();
    idle();
    res("alias1100", 1'b1, 1'b0, 32'h0);

    // Invalidate then lookup
    up(32'h100, 1'b0, 32'h0);
    #1;
    check("inval.wena", {31'd0, ram_wena}, 32'd0);
    cyc();
    idle();
    lk(32'h100);
    cyc();
    idle();
    res("inval", 1'b1, 1'b0, 32'h0);

    // Same-cycle, same-index update and lookup on an empty entry
    up(32'h100, 1'b1, 32'h3000);
    lk(32'h100);
    cyc();
    idle();
    lk(32'h100);
`ifdef SCR1_BTB_BYPASS_EN
    res("coll", 1'b1, 1'b1, 32'h3000);
`else
    res("coll", 1'b1, 1'b0, 32'h0);
`endif
    cyc();
    idle();
    res("coll.re", 1'b1, 1'b1, 32'h3000);

    // Install more entries (idx 2, 4, 6), then lookup with a different-index update
    up(32'h104, 1'b1, 32'h4000);
    cyc();
    up(32'h108, 1'b1, 32'h5000);
    cyc();
    up(32'h10C, 1'b1, 32'h6000);
    lk(32'h104);
    cyc();
    idle();
    res("diffidx", 1'b1, 1'b1, 32'h4000);
    up(32'h100, 1'b1, 32'h2000);
    cyc();
    idle();

    // Flush concurrent with update and lookup
    flush = 1'b1;
    up(32'h140, 1'b1, 32'h7000);
    lk(32'h100);
    #1;
    check("flush.wena", {31'd0, ram_wena}, 32'd0);
    cyc();
    idle();
    res("flush", 1'b0, 1'b0, 32'h0);
    begin
      logic [31:0] pcs [5];
      pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
      pcs[3] = 32'h10C; pcs[4] = 32'h140;
      for (int i = 0; i < 5; i++) begin
        lk(pcs[i]);
        cyc();
        idle();
        res($sformatf("postflush%0d", i), 1'b1, 1'b0, 32'h0);
      end
    end

    // Reinstall, then back-to-back lookups
    up(32'h100, 1'b1, 32'h2000);
    cyc();
    up(32'h104, 1'b1, 32'h4000);
    cyc();
    idle();
    lk(32'h100);
    cyc();
    lk(32'h104);
    res("b2b0", 1'b1, 1'b1, 32'h2000);
    cyc();
    lk(32'h100);
    res("b2b1", 1'b1, 1'b1, 32'h4000);
    cyc();
    lk(32'h104);
    res("b2b2", 1'b1, 1'b1, 32'h2000);

    // Asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    res("arst", 1'b0, 1'b0, 32'h0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    // Valid bits cleared by reset even though RAM still holds the entry
    cyc();
    lk(32'h100);
    cyc();
    idle();
    res("postrst", 1'b1, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
